// File: rtl/uart_rx_core_if.sv
// rtl/uart_rx_core_if.sv - receive-byte handshake between uart_rx_core and the rx FIFO
interface uart_rx_core_if #(
   parameter int width = 8
);
   logic [width-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - oversampled UART receiver with 2-flop synchronizer, break detection and overrun flagging
module uart_rx_core #(
   parameter int width      = 8,
   parameter int baud_rate  = 9600,
   parameter int clock_freq = 460800
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rx,
   uart_rx_core_if.master  out_if,
   output logic            frame_error,
   output logic            overrun,
   output logic            busy
);
   localparam int CPB = clock_freq / baud_rate;
   localparam int CW  = $clog2(CPB);
   localparam int IW  = $clog2(width + 1);

   localparam logic [CW-1:0] CNT_HALF = CW'(CPB / 2 - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(width - 1);

   if (CPB < 4) begin : g_cpb_check
      $error("uart_rx_core: clock_freq/baud_rate must be at least 4");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic [IW-1:0]    r_idx, w_idx_nxt;
   logic [width-1:0] r_shift, w_shift_nxt;
   logic [width-1:0] r_data, w_data_nxt;
   logic             r_valid, w_valid_nxt;
   logic             r_fe, w_fe_nxt;
   logic             r_ov, w_ov_nxt;
   logic             r_rx_m, r_rx_s;
   logic             w_deliver;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_m  <= 1'b1;
         r_rx_s  <= 1'b1;
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_data  <= '0;
         r_valid <= 1'b0;
         r_fe    <= 1'b0;
         r_ov    <= 1'b0;
      end else begin
         r_rx_m  <= rx;
         r_rx_s  <= r_rx_m;
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_shift <= w_shift_nxt;
         r_data  <= w_data_nxt;
         r_valid <= w_valid_nxt;
         r_fe    <= w_fe_nxt;
         r_ov    <= w_ov_nxt;
      end
   end

   // Start bit is re-checked mid-bit; data and stop bits are then sampled one full bit apart.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_deliver   = 1'b0;
      w_fe_nxt    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!r_rx_s) begin
               w_state_nxt = S_START;
               w_cnt_nxt   = '0;
            end
         end
         S_START: begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == CNT_HALF) begin
               w_cnt_nxt   = '0;
               w_idx_nxt   = '0;
               w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) begin
               w_shift_nxt = {r_rx_s, r_shift[width-1:1]};
               w_cnt_nxt   = '0;
               w_idx_nxt   = r_idx + 1'b1;
               if (r_idx == IDX_LAST) begin
                  w_state_nxt = S_STOP;
               end
            end
         end
         S_STOP: begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) begin
               w_cnt_nxt = '0;
               if (r_rx_s) begin
                  w_deliver   = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_fe_nxt    = 1'b1;
                  w_state_nxt = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            if (r_rx_s) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // A consumed byte frees the holding register in the same cycle a new one arrives.
   always_comb begin
      w_data_nxt  = r_data;
      w_valid_nxt = r_valid;
      w_ov_nxt    = 1'b0;
      if (r_valid && out_if.out_ready) begin
         w_valid_nxt = 1'b0;
      end
      if (w_deliver) begin
         if (!r_valid || out_if.out_ready) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
         end else begin
            w_ov_nxt = 1'b1;
         end
      end
   end

   assign out_if.out_data  = r_data;
   assign out_if.out_valid = r_valid;
   assign frame_error      = r_fe;
   assign overrun          = r_ov;
   assign busy             = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - self-checking bench for uart_rx_core
module tb_uart_rx_core;
   localparam int CPB = 48;
   localparam int LAT = CPB / 2 + 9 * CPB + 3;

   logic clk = 1'b0;
   logic rst;
   logic rx;
   logic frame_error, overrun, busy;

   uart_rx_core_if #(.width(8)) u_if ();

   uart_rx_core #(
      .width(8),
      .baud_rate(9600),
      .clock_freq(460800)
   ) dut (
      .clk(clk),
      .rst(rst),
      .rx(rx),
      .out_if(u_if.master),
      .frame_error(frame_error),
      .overrun(overrun),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      int         exp_bytes;
      logic [7:0] exp_data;
      int         exp_fe;
   } vec_t;

   vec_t       tbl[6];
   logic [7:0] got[$];
   logic [7:0] exp_q[$];
   int cyc = 0;
   int n_pass = 0, n_total = 0;
   int fe_cnt = 0, ov_cnt = 0, both_cnt = 0, stab_err = 0;
   int vrun = 0, max_vrun = 0;
   int rise_cyc = 0, start_cyc = 0;
   logic       prev_valid = 1'b0, prev_hs = 1'b0;
   logic [7:0] prev_data = 8'h00;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst) begin
         vrun       = 0;
         prev_valid = 1'b0;
         prev_hs    = 1'b0;
      end else begin
         if (u_if.out_valid && u_if.out_ready) got.push_back(u_if.out_data);
         if (frame_error) fe_cnt++;
         if (overrun) ov_cnt++;
         if (frame_error && overrun) both_cnt++;
         if (u_if.out_valid && !prev_valid) rise_cyc = cyc;
         if (u_if.out_valid && prev_valid && !prev_hs && u_if.out_data != prev_data) stab_err++;
         vrun = u_if.out_valid ? vrun + 1 : 0;
         if (vrun > max_vrun) max_vrun = vrun;
         prev_valid = u_if.out_valid;
         prev_hs    = u_if.out_valid && u_if.out_ready;
         prev_data  = u_if.out_data;
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation still running, expected to finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic hold(input logic b, input int n);
      rx = b;
      repeat (n) tick();
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_bit);
      start_cyc = cyc;
      hold(1'b0, CPB);
      for (int i = 0; i < 8; i++) hold(d[i], CPB);
      hold(stop_bit, CPB);
      rx = 1'b1;
   endtask

   function automatic int last_byte(input int n0);
      return (got.size() > n0) ? int'(got[got.size()-1]) : -1;
   endfunction

   initial begin
      int n0, f0, o0, gap;
      logic [7:0] d;
      logic       s;
      logic [7:0] a5;

      tbl[0] = '{8'hA5, 1'b1, 1, 8'hA5, 0};
      tbl[1] = '{8'h3C, 1'b0, 0, 8'h00, 1};
      tbl[2] = '{8'h5A, 1'b1, 1, 8'h5A, 0};
      tbl[3] = '{8'h00, 1'b1, 1, 8'h00, 0};
      tbl[4] = '{8'hFF, 1'b1, 1, 8'hFF, 0};
      tbl[5] = '{8'h7E, 1'b1, 1, 8'h7E, 0};

      rst = 1'b1;
      rx = 1'b1;
      u_if.out_ready = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      check("rst_out_data", int'(u_if.out_data), 0);
      check("rst_out_valid", int'(u_if.out_valid), 0);
      check("rst_frame_error", int'(frame_error), 0);
      check("rst_overrun", int'(overrun), 0);
      check("rst_busy", int'(busy), 0);
      rst = 1'b0;
      tick();
      hold(1'b1, 8);

      for (int k = 0; k < 6; k++) begin
         n0 = got.size();
         f0 = fe_cnt;
         max_vrun = 0;
         send_frame(tbl[k].data, tbl[k].stop);
         hold(1'b1, 2 * CPB);
         check($sformatf("tbl%0d_count", k), got.size() - n0, tbl[k].exp_bytes);
         if (tbl[k].exp_bytes > 0)
            check($sformatf("tbl%0d_data", k), last_byte(n0), int'(tbl[k].exp_data));
         check($sformatf("tbl%0d_fe", k), fe_cnt - f0, tbl[k].exp_fe);
         check($sformatf("tbl%0d_valid_len", k), max_vrun, tbl[k].exp_bytes);
         if (k == 0) check("latency", rise_cyc - start_cyc, LAT);
      end

      n0 = got.size();
      hold(1'b0, 6);
      @(negedge clk);
      check("glitch_busy_high", int'(busy), 1);
      hold(1'b0, 4);
      hold(1'b1, 40);
      @(negedge clk);
      check("glitch_busy_low", int'(busy), 0);
      check("glitch_no_byte", got.size() - n0, 0);
      tick();

      n0 = got.size();
      f0 = fe_cnt;
      send_frame(8'h3C, 1'b0);
      hold(1'b0, 200);
      @(negedge clk);
      check("break_busy", int'(busy), 1);
      check("break_fe_once", fe_cnt - f0, 1);
      check("break_no_byte", got.size() - n0, 0);
      tick();
      hold(1'b1, 4);
      @(negedge clk);
      check("break_exit", int'(busy), 0);
      tick();
      hold(1'b1, CPB);
      send_frame(8'h5A, 1'b1);
      hold(1'b1, 2 * CPB);
      check("after_break_count", got.size() - n0, 1);
      check("after_break_data", last_byte(n0), 8'h5A);

      u_if.out_ready = 1'b0;
      n0 = got.size();
      o0 = ov_cnt;
      send_frame(8'h11, 1'b1);
      hold(1'b1, CPB);
      send_frame(8'h22, 1'b1);
      hold(1'b1, CPB);
      @(negedge clk);
      check("ovr_valid_held", int'(u_if.out_valid), 1);
      check("ovr_data_held", int'(u_if.out_data), 8'h11);
      check("ovr_pulse_once", ov_cnt - o0, 1);
      tick();
      u_if.out_ready = 1'b1;
      tick();
      @(negedge clk);
      check("ovr_valid_fall", int'(u_if.out_valid), 0);
      check("ovr_consumed", got.size() - n0, 1);
      check("ovr_consumed_data", last_byte(n0), 8'h11);
      tick();

      n0 = got.size();
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h81, 1'b1);
      hold(1'b1, 2 * CPB);
      check("b2b_count", got.size() - n0, 3);
      check("b2b_0", (got.size() > n0) ? int'(got[n0]) : -1, 8'h00);
      check("b2b_1", (got.size() > n0 + 1) ? int'(got[n0+1]) : -1, 8'hFF);
      check("b2b_2", (got.size() > n0 + 2) ? int'(got[n0+2]) : -1, 8'h81);

      n0 = got.size();
      a5 = 8'hA5;
      hold(1'b0, CPB);
      for (int i = 0; i < 4; i++) hold(a5[i], CPB);
      hold(a5[4], CPB / 2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rx = 1'b1;
      @(negedge clk);
      check("midrst_out_data", int'(u_if.out_data), 0);
      check("midrst_out_valid", int'(u_if.out_valid), 0);
      check("midrst_frame_error", int'(frame_error), 0);
      check("midrst_overrun", int'(overrun), 0);
      check("midrst_busy", int'(busy), 0);
      tick();
      hold(1'b1, 3 * CPB);
      send_frame(8'h7E, 1'b1);
      hold(1'b1, 2 * CPB);
      check("midrst_next_count", got.size() - n0, 1);
      check("midrst_next_data", last_byte(n0), 8'h7E);

      n0 = got.size();
      f0 = fe_cnt;
      o0 = ov_cnt;
      max_vrun = 0;
      exp_q.delete();
      for (int k = 0; k < 20; k++) begin
         d = 8'($urandom);
         s = ($urandom_range(0, 4) != 0);
         send_frame(d, s);
         if (s) exp_q.push_back(d);
         gap = $urandom_range(0, 2 * CPB) + (s ? 0 : CPB);
         if (gap > 0) hold(1'b1, gap);
      end
      hold(1'b1, 2 * CPB);
      check("rand_count", got.size() - n0, exp_q.size());
      for (int k = 0; k < exp_q.size(); k++)
         check($sformatf("rand_byte%0d", k),
               (got.size() > n0 + k) ? int'(got[n0+k]) : -1, int'(exp_q[k]));
      check("rand_fe", fe_cnt - f0, 20 - exp_q.size());
      check("rand_overrun", ov_cnt - o0, 0);
      check("rand_valid_len", max_vrun, (exp_q.size() > 0) ? 1 : 0);

      check("fe_ov_exclusive", both_cnt, 0);
      check("data_stable", stab_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter width, default 8: data bits per frame.
REQ-002 SHALL have parameter baud_rate, default 9600: serial bit rate.
REQ-003 SHALL have parameter clock_freq, default 460800: clk frequency in Hz; CPB = clock_freq/baud_rate (integer division, default 48), and CPB SHALL be >= 4.
REQ-004 SHALL have port: clk  input  1  the single clock; all logic is on the rising edge.
REQ-005 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port: rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port: out_data  output  width  received byte for the buffered-UART rx FIFO.
REQ-008 SHALL have port: out_valid  output  1  out_data holds an unconsumed byte.
REQ-009 SHALL have port: out_ready  input  1  FIFO accepts the byte.
REQ-010 SHALL have port: frame_error  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 SHALL have port: overrun  output  1  one-cycle pulse: new byte dropped because out_valid was still high.
REQ-012 SHALL have port: busy  output  1  FSM is not in IDLE.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer (rx_s); both flops SHALL reset to 1; all FSM decisions SHALL use rx_s only.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP and BREAK, with a bit counter cnt of width clog2(CPB) and a bit index idx of width clog2(width+1).
REQ-015 IDLE: SHALL go to START with cnt=0 when rx_s==0; otherwise SHALL stay in IDLE.
REQ-016 START: SHALL increment cnt; at cnt==CPB/2-1 SHALL sample rx_s; if 0, SHALL go to DATA with cnt=0 and idx=0; if 1 (glitch), SHALL go to IDLE without producing output.
REQ-017 DATA: SHALL increment cnt; at cnt==CPB-1 SHALL shift rx_s into the shift register LSB-first, set cnt=0 and increment idx; after the width-th sample SHALL go to STOP.
REQ-018 STOP: at cnt==CPB-1 SHALL sample rx_s; if 1, SHALL deliver the byte (REQ-019) and go to IDLE; if 0, SHALL pulse frame_error the next cycle, discard the byte, and go to BREAK.
REQ-019 Delivery: if out_valid==0, or out_valid==1 and out_ready==1 in the same cycle, SHALL load out_data and set out_valid=1 on the next cycle; otherwise SHALL keep out_data unchanged and pulse overrun for one cycle.
REQ-020 Handshake: out_valid SHALL clear on the cycle after out_valid && out_ready unless a load coincides; out_data SHALL be stable while out_valid is high.
REQ-021 BREAK: SHALL stay in BREAK while rx_s==0 and go to IDLE on the first cycle with rx_s==1.
REQ-022 Latency: out_valid SHALL rise exactly 1 cycle after the stop-bit sample cycle; stop-bit sampling SHALL occur (CPB/2) + (width+1)*CPB cycles after IDLE sees rx_s==0.
REQ-023 Back-to-back frames: a start bit that follows a stop bit immediately SHALL be detected, because IDLE is re-entered within the stop-bit half-period.
REQ-024 out_ready SHALL be ignored while out_valid==0; frame_error and overrun SHALL never both be high in the same cycle.

Reset
REQ-025 On rst==1 at a clk edge: state=IDLE, cnt=0, idx=0, shift register=0, out_data=0, out_valid=0, frame_error=0, overrun=0, busy=0, synchronizer flops=1.
REQ-026 Reset mid-frame SHALL abort the frame with no output; the following frame SHALL be received correctly.

Verification
REQ-027 CPB=48, out_ready=1: send 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1) -> out_data=0xA5, out_valid pulses 1 cycle, frame_error=0.
REQ-028 rx low for 10 cycles, then high -> FSM returns to IDLE from START; out_valid stays 0 and busy falls.
REQ-029 Send 0x3C with stop bit=0, then hold rx low 200 cycles -> frame_error pulses once, out_valid stays 0, FSM stays in BREAK until rx rises, then the next frame 0x5A is received correctly.
REQ-030 out_ready=0: send 0x11, then 0x22 -> out_data=0x11 held, overrun pulses once at the end of the 0x22 frame; after raising out_ready, 0x11 is consumed and out_valid falls.
REQ-031 Back-to-back frames 0x00, 0xFF, 0x81 with no idle gap and out_ready=1 -> three valid bytes delivered in order.
REQ-032 Assert rst for 1 cycle during DATA bit 4 -> all outputs take their reset values, no byte is delivered, and the next full frame 0x7E is received correctly.
